// File: rtl/mux_arb_2x4_pkg.sv
// mux_arb_2x4_pkg: shared state encoding and widths for the 2x4 mux arbiter.
package mux_arb_2x4_pkg;
    localparam int DATA_W  = 4;
    localparam int BEATS_W = 4;
    localparam int GAP_W   = 3;
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, TURN = 2'd2} state_t;
endpackage

// File: rtl/mux_arb_2x4_mux.sv
// mux_2in4bit: 4-bit 2:1 data mux with active-low enable; drives zero when disabled.
module mux_2in4bit
    import mux_arb_2x4_pkg::*;
(
    input  logic              EN_L,
    input  logic              S,
    input  logic [DATA_W:1]   D0,
    input  logic [DATA_W:1]   D1,
    output logic [DATA_W:1]   Y
);
    assign Y = EN_L ? '0 : (S ? D1 : D0);
endmodule

// File: rtl/mux_arb_2x4.sv
// mux_arb_2x4: round-robin two-requester arbiter sequencing a shared 4-bit mux,
// with bounded bursts, turnaround gaps and a registered valid-qualified output.
module mux_arb_2x4
    import mux_arb_2x4_pkg::*;
#(
    parameter int MAX_BEATS = 4,
    parameter int IDLE_GAP  = 1
)(
    input  logic              CLK,
    input  logic              RST_L,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic              LAST0,
    input  logic              LAST1,
    input  logic [DATA_W:1]   D0,
    input  logic [DATA_W:1]   D1,
    input  logic              READY,
    output logic              GNT0,
    output logic              GNT1,
    output logic              EN_L,
    output logic              S,
    output logic [DATA_W:1]   Y,
    output logic              VALID
);
    state_t               state;
    logic                 sel;
    logic                 ptr;
    logic [BEATS_W-1:0]   beats;
    logic [BEATS_W-1:0]   beats_nxt;
    logic [GAP_W-1:0]     gap;
    logic [DATA_W:1]      mux_y;
    logic                 req_sel;
    logic                 last_sel;
    logic                 beat;
    logic                 grant_end;

    assign req_sel   = sel ? REQ1 : REQ0;
    assign last_sel  = sel ? LAST1 : LAST0;
    assign beat      = (state == GRANT) && READY && req_sel;
    assign beats_nxt = beats + 1'b1;
    // A dropped request ends the grant even if READY is high that cycle.
    assign grant_end = (state == GRANT) &&
                       (!req_sel || (beat && (last_sel || beats_nxt == BEATS_W'(MAX_BEATS))));

    assign EN_L = state != GRANT;
    assign S    = sel;
    assign GNT0 = !EN_L && !sel;
    assign GNT1 = !EN_L && sel;

    mux_2in4bit u_mux (
        .EN_L (EN_L),
        .S    (S),
        .D0   (D0),
        .D1   (D1),
        .Y    (mux_y)
    );

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            state <= IDLE;
            sel   <= 1'b0;
            ptr   <= 1'b0;
            beats <= '0;
            gap   <= '0;
            Y     <= '0;
            VALID <= 1'b0;
        end else begin
            case (state)
                IDLE: if (REQ0 || REQ1) begin
                    sel   <= (REQ0 && REQ1) ? ptr : REQ1;
                    beats <= '0;
                    state <= GRANT;
                end
                GRANT: begin
                    if (beat) beats <= beats_nxt;
                    if (grant_end) begin
                        ptr   <= ~sel;
                        gap   <= '0;
                        state <= (IDLE_GAP > 0) ? TURN : IDLE;
                    end
                end
                TURN: begin
                    gap <= gap + 1'b1;
                    if (gap == GAP_W'(IDLE_GAP - 1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            VALID <= beat;
            if (beat) Y <= mux_y;
        end
    end
endmodule

// File: tb/tb_mux_arb_2x4.sv
// tb_mux_arb_2x4: directed scoreboard bench; instance 0 uses MAX_BEATS=4/IDLE_GAP=1,
// instance 1 the MAX_BEATS=1/IDLE_GAP=0 corner, both on shared stimulus.
module tb_mux_arb_2x4;
    typedef struct packed {
        logic       v;
        logic [4:1] y;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST_L, REQ0, REQ1, LAST0, LAST1, READY;
    logic [4:1] D0, D1;
    logic [1:0] g0, g1, en_l, s, valid;
    logic [4:1] y [2];
    exp_t       sb [$];
    int         checks = 0;
    int         errors = 0;

    always #5 CLK = ~CLK;

    mux_arb_2x4 #(.MAX_BEATS(4), .IDLE_GAP(1)) u0 (
        .CLK(CLK), .RST_L(RST_L), .REQ0(REQ0), .REQ1(REQ1), .LAST0(LAST0), .LAST1(LAST1),
        .D0(D0), .D1(D1), .READY(READY), .GNT0(g0[0]), .GNT1(g1[0]), .EN_L(en_l[0]),
        .S(s[0]), .Y(y[0]), .VALID(valid[0])
    );

    mux_arb_2x4 #(.MAX_BEATS(1), .IDLE_GAP(0)) u1 (
        .CLK(CLK), .RST_L(RST_L), .REQ0(REQ0), .REQ1(REQ1), .LAST0(LAST0), .LAST1(LAST1),
        .D0(D0), .D1(D1), .READY(READY), .GNT0(g0[1]), .GNT1(g1[1]), .EN_L(en_l[1]),
        .S(s[1]), .Y(y[1]), .VALID(valid[1])
    );

    // Output vector layout: {VALID, Y, GNT0, GNT1, EN_L, S}.
    task automatic cyc(input int k, input string tag, input logic ev, input logic [4:1] ey,
                       input logic eg0, input logic eg1, input logic een, input logic es);
        exp_t       e;
        logic [8:0] obs, ex;
        e.v = ev;
        e.y = ey;
        sb.push_back(e);
        @(negedge CLK);
        e   = sb.pop_front();
        obs = {valid[k], y[k], g0[k], g1[k], en_l[k], s[k]};
        ex  = {e.v, e.y, eg0, eg1, een, es};
        checks++;
        assert (obs === ex) else begin
            errors++;
            $error("FAIL %s u%0d: observed %b required %b", tag, k, obs, ex);
        end
    endtask

    task automatic rst_chk(input string tag);
        logic [8:0] obs;
        for (int k = 0; k < 2; k++) begin
            obs = {valid[k], y[k], g0[k], g1[k], en_l[k], s[k]};
            checks++;
            assert (obs === 9'b0_0000_0010) else begin
                errors++;
                $error("FAIL %s u%0d: observed %b required %b", tag, k, obs, 9'b0_0000_0010);
            end
        end
    endtask

    task automatic do_reset();
        RST_L = 1'b0;
        @(negedge CLK);
        RST_L = 1'b1;
    endtask

    initial begin
        logic [4:1] d, yl;
        logic       w;
        RST_L = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0; LAST0 = 1'b0; LAST1 = 1'b0;
        D0 = '0; D1 = '0; READY = 1'b0;
        repeat (2) @(negedge CLK);
        rst_chk("reset_values");
        RST_L = 1'b1;

        REQ0 = 1'b1; READY = 1'b1; D0 = 4'hA;
        cyc(0, "burst_gnt", 0, 4'h0, 1, 0, 0, 0);
        cyc(0, "burst_a",   1, 4'hA, 1, 0, 0, 0);
        D0 = 4'hB;
        cyc(0, "burst_b",   1, 4'hB, 1, 0, 0, 0);
        D0 = 4'hC; LAST0 = 1'b1;
        cyc(0, "burst_c",   1, 4'hC, 0, 0, 1, 0);
        REQ0 = 1'b0; LAST0 = 1'b0;
        cyc(0, "burst_turn", 0, 4'hC, 0, 0, 1, 0);
        cyc(0, "burst_idle", 0, 4'hC, 0, 0, 1, 0);

        do_reset();
        REQ0 = 1'b1; REQ1 = 1'b1; READY = 1'b1;
        yl = 4'h0;
        for (int g = 0; g < 3; g++) begin
            w = g[0];
            cyc(0, "rr_gnt", 0, yl, !w, w, 0, w);
            for (int i = 0; i < 4; i++) begin
                d  = 4'(g * 4 + i + 1);
                D0 = d;
                D1 = ~d;
                yl = w ? ~d : d;
                cyc(0, "rr_beat", 1, yl, !w && i < 3, w && i < 3, i == 3, w);
            end
            cyc(0, "rr_turn", 0, yl, 0, 0, 1, w);
        end
        REQ0 = 1'b0; REQ1 = 1'b0;

        REQ1 = 1'b1; D1 = 4'h7;
        cyc(0, "bp_gnt",    0, yl,   0, 1, 0, 1);
        cyc(0, "bp_beat1",  1, 4'h7, 0, 1, 0, 1);
        READY = 1'b0; D1 = 4'hE;
        cyc(0, "bp_stall1", 0, 4'h7, 0, 1, 0, 1);
        cyc(0, "bp_stall2", 0, 4'h7, 0, 1, 0, 1);
        READY = 1'b1; D1 = 4'h6;
        cyc(0, "bp_beat2",  1, 4'h6, 0, 1, 0, 1);
        REQ1 = 1'b0; D1 = 4'h5;
        cyc(0, "abandon",      0, 4'h6, 0, 0, 1, 1);
        REQ0 = 1'b1; REQ1 = 1'b1;
        cyc(0, "abandon_turn", 0, 4'h6, 0, 0, 1, 1);
        LAST0 = 1'b1; D0 = 4'h2;
        cyc(0, "tie_to_0",     0, 4'h6, 1, 0, 0, 0);
        cyc(0, "last_first",   1, 4'h2, 0, 0, 1, 0);
        REQ0 = 1'b0; REQ1 = 1'b0; LAST0 = 1'b0;
        cyc(0, "last_turn",    0, 4'h2, 0, 0, 1, 0);

        REQ0 = 1'b1;
        cyc(0, "lm_gnt", 0, 4'h2, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            d = 4'(i + 8);
            D0 = d;
            LAST0 = (i == 3);
            cyc(0, "lm_beat", 1, d, i < 3, 0, i == 3, 0);
        end
        REQ0 = 1'b0; LAST0 = 1'b0;
        cyc(0, "lm_turn", 0, 4'hB, 0, 0, 1, 0);
        cyc(0, "lm_idle", 0, 4'hB, 0, 0, 1, 0);

        REQ0 = 1'b1; D0 = 4'hF;
        cyc(0, "rst_gnt",  0, 4'hB, 1, 0, 0, 0);
        cyc(0, "rst_beat", 1, 4'hF, 1, 0, 0, 0);
        #2 RST_L = 1'b0;
        #1 rst_chk("async_reset");
        @(negedge CLK);
        RST_L = 1'b1;
        cyc(0, "post_reset_gnt", 0, 4'h0, 1, 0, 0, 0);

        do_reset();
        REQ0 = 1'b1; REQ1 = 1'b1; READY = 1'b1; D0 = 4'h3; D1 = 4'hC;
        yl = 4'h0;
        for (int g = 0; g < 4; g++) begin
            w = g[0];
            cyc(1, "cn_gnt", 0, yl, !w, w, 0, w);
            yl = w ? 4'hC : 4'h3;
            cyc(1, "cn_beat", 1, yl, 0, 0, 1, w);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux_arb_2x4.md
# mux_arb_2x4

Two-requester round-robin arbiter and sequencer for the 4-bit 2:1 data mux.
- Grants the shared 4-bit path to one requester at a time for a bounded burst.
- Drives the mux's active-low enable and select, and inserts turnaround cycles between owners.
- Registers the selected data onto a valid-qualified output bus towards a single sink that can stall.

## Interface
Parameters:
- MAX_BEATS, 4: maximum beats per grant; legal range 1..15.
- IDLE_GAP, 1: turnaround cycles (mux disabled) after each grant; legal range 0..7.

Ports:
- CLK  in  1  single clock, rising edge.
- RST_L  in  1  asynchronous, active-low reset.
- REQ0, REQ1  in  1 each  requester wants the path; must be held until the grant ends.
- LAST0, LAST1  in  1 each  marks the current beat as the requester's final beat; sampled only on a beat.
- D0, D1  in  [4:1] each  requester data.
- READY  in  1  sink can accept a beat this cycle.
- GNT0, GNT1  out  1 each  grant; at most one is high.
- EN_L  out  1  mux enable, active-low; low only in GRANT.
- S  out  1  mux select; 0 selects D0, 1 selects D1.
- Y  out  [4:1]  registered output data.
- VALID  out  1  Y holds a transferred beat.

## Operation
States: IDLE, GRANT, TURN.
- **IDLE**
  - EN_L=1, GNT0=GNT1=0, S holds its last value.
  - If only one REQ is high, that requester wins.
  - If both are high, the round-robin pointer PTR picks the winner.
  - On a win: latch the winner into SEL, clear BEATS, go to GRANT.
- **GRANT**
  - EN_L=0, S=SEL, GNT[SEL]=1.
  - beat = READY & REQ[SEL]. Each beat increments BEATS.
  - The grant ends when any of these holds:
    - a beat occurs with LAST[SEL]=1;
    - a beat brings BEATS to MAX_BEATS;
    - REQ[SEL]=0. This is an abandon with no transfer that cycle.
  - On grant end: PTR <= ~SEL. Go to TURN if IDLE_GAP>0, else go to IDLE.
- **TURN**
  - EN_L=1, GNTs low.
  - Gap counter runs IDLE_GAP cycles, then the state returns to IDLE.
  - REQs are ignored during TURN.
- **Output register**
  - On a beat: Y <= mux output (D[SEL]), VALID <= 1.
  - Otherwise: VALID <= 0 and Y holds its value.
- **Width rules**
  - BEATS is 4 bits and never exceeds MAX_BEATS.
  - The gap counter is 3 bits.
  - No wrap-around is possible within the legal parameter ranges.
- **Fairness**: the requester that just finished loses any tie at the next IDLE. An abandoned grant still advances PTR.

## Timing
- **Reset values**
  - Outputs: GNT0=GNT1=0, EN_L=1, S=0, Y=4'h0, VALID=0.
  - Internal: state IDLE, PTR=0 (requester 0 favoured), BEATS=0, gap=0.
  - Reset is asynchronous and takes effect mid-burst. The in-flight beat is dropped, with no VALID after the reset edge.
- **Grant latency**: REQ sampled high in IDLE at edge n gives GNT, EN_L=0 and S valid from edge n through edge n+1. GNT, EN_L and S are decoded from registered state only.
- **Data latency**: a beat at edge n (sampled READY, REQ and D) shows Y/VALID after edge n, i.e. one cycle later.
- **Stall**: READY=0 in GRANT holds the state and BEATS. GNT stays high and VALID goes low next cycle.
- **Grant end**: the final beat's edge moves the state to TURN or IDLE, so GNT drops in the same cycle that VALID shows the last beat.
- **Minimum spacing**: with IDLE_GAP=g, consecutive grants are separated by g+1 cycles with EN_L=1 (g TURN cycles plus 1 IDLE).
- **Simultaneous events**:
  - LAST and MAX_BEATS on the same beat: one grant end, no double count.
  - REQ falling together with READY=1 is an abandon, with no beat.

## Structure
- Shared package: state encoding (IDLE=2'd0, GRANT=2'd1, TURN=2'd2), 4-bit data width constant, BEATS and gap counter widths.
- Sub-module: one instance of mux_2in4bit, driven by EN_L and S from the FSM. Its Y feeds the output register.
- FSM, PTR, the two counters and the output register live in mux_arb_2x4.

## Test plan
- **Reset**: RST_L low mid-GRANT -> outputs at reset values immediately (asynchronously); after release, REQ0=1 -> GNT0 one cycle later.
- **Single burst**: REQ0=1, D0=4'hA,B,C with READY=1 and LAST0 on the third beat -> VALID on 3 consecutive cycles with Y=A,B,C; GNT0 drops; EN_L=1 for IDLE_GAP+1 cycles.
- **Round-robin**: REQ0=REQ1=1 held, LAST never, MAX_BEATS=4 -> grants alternate 0,1,0 with 4 beats each and S toggling per grant.
- **Backpressure**: during a grant, READY toggles 1,0,0,1 -> exactly 2 beats counted, Y stable and VALID low on stall cycles.
- **Abandon**: REQ1 drops after 1 beat -> no further VALID; the next tie goes to requester 0.
- **Parameter corners**: IDLE_GAP=0 and MAX_BEATS=1 -> with both requesters requesting, one beat per grant, alternating owners every 2 cycles.
